slice_buffer_responder: RTL and testbench

- Memory-side responder for the column-parity encoder: holds one 64-slice x 25-bit input state and serves `line_in` by the encoder's `cnt_value`.
- Captures the encoder's `write_enable`/`write_value` stream into a result buffer, then streams the results out to the host.
- Replaces the behavioural memory and file capture used around the encoder with synthesizable RTL. Sits between the host bus and the encoder.

---
 rtl/slice_buffer_responder.sv | 164 ++++++++++++++++
 tb/tb_slice_buffer_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/slice_buffer_responder.sv
// Memory-side responder for the column-parity encoder: buffers one input
// state, serves the encoder by index, captures its results, unloads them.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   load_valid/data/ready    host slice stream in, slice 0 first
//   enc_start, enc_done      encoder start level and done input
//   cnt_value, line_out      encoder read index and combinational slice
//   write_enable/value       encoder result strobe and result slice
//   res_valid/data/ready     result slice stream out, slice 0 first
//   busy, err                not idle; sticky protocol error
module slice_buffer_responder #(
    parameter int SLICE_W = 25,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [SLICE_W-1:0] load_data,
    output logic               load_ready,
    output logic               enc_start,
    input  logic               enc_done,
    input  logic [ADDR_W-1:0]  cnt_value,
    output logic [SLICE_W-1:0] line_out,
    input  logic               write_enable,
    input  logic [SLICE_W-1:0] write_value,
    output logic               res_valid,
    output logic [SLICE_W-1:0] res_data,
    input  logic               res_ready,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);

    state_t state;
    state_t state_nx;

    logic [SLICE_W-1:0] in_mem  [DEPTH];
    logic [SLICE_W-1:0] res_mem [DEPTH];

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    // One bit wider than an address so it can sit at DEPTH (full)
    logic [ADDR_W:0]   cptr;
    logic [ADDR_W:0]   cptr_after;
    logic              we_d;

    logic load_fire;
    logic last_load;
    logic we_rise;
    logic cap_ok;
    logic res_fire;
    logic last_res;

    // Gated by rst so the host sees no ready while reset is held
    assign load_ready = rst & ((state == S_IDLE) | (state == S_LOAD));
    assign enc_start  = (state == S_RUN);
    assign busy       = (state != S_IDLE);
    assign line_out   = in_mem[cnt_value];

    assign load_fire  = load_valid & load_ready;
    assign last_load  = load_fire & (wptr == LAST_ADDR);
    // A held strobe counts once: only its rising edge captures
    assign we_rise    = write_enable & ~we_d;
    assign cap_ok     = (state == S_RUN) & we_rise & (cptr != CNT_FULL);
    assign cptr_after = cap_ok ? cptr + 1'b1 : cptr;
    assign res_fire   = res_valid & res_ready;
    assign last_res   = res_fire & (rptr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (load_fire) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (last_load) state_nx = S_RUN;
            end
            S_RUN: begin
                if (cptr_after == CNT_FULL || enc_done) state_nx = S_DRAIN;
            end
            // One cycle with start low so the encoder sees it fall
            S_DRAIN: begin
                state_nx = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (last_res) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cptr      <= '0;
            we_d      <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            we_d <= write_enable;

            if (load_fire) wptr <= wptr + 1'b1;

            if (state == S_LOAD && last_load) begin
                cptr <= '0;
            end else if (cap_ok) begin
                cptr <= cptr + 1'b1;
            end

            // Strobes outside RUN or past a full buffer are protocol errors
            if (we_rise && (state != S_RUN || cptr == CNT_FULL)) begin
                err <= 1'b1;
            end
            // Done before every slice came back: the tail is stale
            if (state == S_RUN && enc_done && cptr_after != CNT_FULL) begin
                err <= 1'b1;
            end

            if (state == S_DRAIN) begin
                rptr      <= '0;
                res_valid <= 1'b1;
                res_data  <= res_mem[0];
            end else if (state == S_UNLOAD && res_fire) begin
                if (last_res) begin
                    res_valid <= 1'b0;
                end else begin
                    rptr     <= rptr + 1'b1;
                    res_data <= res_mem[rptr + 1'b1];
                end
            end
        end
    end

    // Storage arrays carry no reset; contents are undefined after reset
    always_ff @(posedge clk) begin
        if (load_fire) in_mem[wptr] <= load_data;
        if (cap_ok) res_mem[cptr[ADDR_W-1:0]] <= write_value;
    end

endmodule

// File: tb/tb_slice_buffer_responder.sv
// Directed bench for slice_buffer_responder: load, encoder model,
// result unload, early done, stray strobes, async reset.
module tb_slice_buffer_responder;

    localparam int SW = 25;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic [SW-1:0] load_data = '0;
    logic          load_ready;
    logic          enc_start;
    logic          enc_done = 1'b0;
    logic [5:0]    cnt_value = '0;
    logic [SW-1:0] line_out;
    logic          write_enable = 1'b0;
    logic [SW-1:0] write_value = '0;
    logic          res_valid;
    logic [SW-1:0] res_data;
    logic          res_ready = 1'b0;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [SW-1:0] ld [N];
    logic [SW-1:0] er [N];

    typedef struct {
        logic [5:0]    cnt;
        logic [SW-1:0] line;
    } lv_t;

    lv_t lv [4];

    slice_buffer_responder dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .enc_start    (enc_start),
        .enc_done     (enc_done),
        .cnt_value    (cnt_value),
        .line_out     (line_out),
        .write_enable (write_enable),
        .write_value  (write_value),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] pat(input int mode, input int k);
        logic [31:0] v;
        case (mode)
            0:       v = k * 32'h0002_0001;
            1:       v = (k * 32'h0004_0813) ^ 32'h0155_5555;
            default: v = ~(k * 32'h0000_0F0F) ^ 32'h00A0_0001;
        endcase
        return v[SW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Mid-cycle async reset pulse, released before the next edge
    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_enc_start", enc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic load(input int mode, input int n, input int stray_at);
        for (int k = 0; k < n; k++) begin
            ld[k] = pat(mode, k);
            chk("load_ready", load_ready, 1);
            load_valid   = 1'b1;
            load_data    = ld[k];
            write_enable = (k == stray_at);
            tick();
        end
        load_valid   = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic enc_writes(input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            cnt_value = 6'(k);
            #1;
            chk("line_out_run", line_out, ld[k]);
            write_value  = ~ld[k];
            write_enable = 1'b1;
            repeat (hold) tick();
            write_enable = 1'b0;
            if (k < n - 1) tick();
        end
    endtask

    task automatic unload(input int stall_at);
        int w;
        w = 0;
        res_ready = 1'b0;
        while (res_valid !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        chk("res_valid_wait", res_valid, 1);
        for (int b = 0; b < N; b++) begin
            chk("res_data", res_data, er[b]);
            if (b == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", res_valid, 1);
                    chk("stall_data", res_data, er[b]);
                end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        chk("res_valid_end", res_valid, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        #3;
        chk("reset_load_ready", load_ready, 0);
        chk("reset_enc_start", enc_start, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        rst = 1'b1;
        tick();
        chk("idle_load_ready", load_ready, 1);
        chk("idle_busy", busy, 0);

        // Round trip, pattern 0
        load(0, N, -1);
        chk("rt_enc_start", enc_start, 1);
        chk("rt_busy", busy, 1);
        chk("rt_load_ready", load_ready, 0);
        lv[0] = '{6'd63, pat(0, 63)};
        lv[1] = '{6'd0,  pat(0, 0)};
        lv[2] = '{6'd31, pat(0, 31)};
        lv[3] = '{6'd1,  pat(0, 1)};
        for (int i = 0; i < 4; i++) begin
            cnt_value = lv[i].cnt;
            #1;
            chk("line_sweep", line_out, lv[i].line);
        end
        enc_writes(N, 1);
        chk("drain_enc_start", enc_start, 0);
        chk("drain_res_valid", res_valid, 0);
        chk("drain_busy", busy, 1);
        tick();
        chk("unload_first_valid", res_valid, 1);
        for (int k = 0; k < N; k++) er[k] = ~ld[k];
        unload(-1);
        chk("rt_err", err, 0);

        // Held strobes, pattern 1, then a 65th pulse
        load(1, N, -1);
        enc_writes(N, 3);
        chk("held_err", err, 0);
        tick();
        write_value  = '1;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        tick();
        chk("extra_pulse_err", err, 1);
        for (int k = 0; k < N; k++) er[k] = ~ld[k];
        unload(-1);

        // Early done after 10 writes; tail keeps pattern-1 results
        pulse_reset();
        load(0, N, -1);
        enc_writes(10, 1);
        tick();
        chk("early_pre_err", err, 0);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("early_err", err, 1);
        chk("early_enc_start", enc_start, 0);
        chk("early_busy", busy, 1);
        for (int k = 0; k < N; k++) begin
            er[k] = (k < 10) ? ~pat(0, k) : ~pat(1, k);
        end
        unload(3);
        chk("early_err_sticky", err, 1);

        // Stray strobe in LOAD, reset at beat 20, reset in RUN
        pulse_reset();
        load(1, 20, 5);
        chk("stray_err", err, 1);
        chk("stray_busy", busy, 1);
        pulse_reset();
        load(2, N, -1);
        chk("run_enc_start", enc_start, 1);
        pulse_reset();
        load(2, N, -1);
        chk("new_enc_start", enc_start, 1);
        enc_writes(N, 1);
        for (int k = 0; k < N; k++) er[k] = ~ld[k];
        unload(-1);
        chk("new_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
